// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory: op codes, controller states,
// fault causes and the latched request record.
package dm_pkg;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_W    = 3'd1;
    localparam logic [2:0] OP_H    = 3'd2;
    localparam logic [2:0] OP_B    = 3'd3;
    localparam logic [2:0] OP_HU   = 3'd4;
    localparam logic [2:0] OP_BU   = 3'd5;

    typedef enum logic [1:0] {CLEAR, IDLE, PEND} state_t;

    localparam logic [1:0] FLT_NONE  = 2'd0;
    localparam logic [1:0] FLT_ALIGN = 2'd1;
    localparam logic [1:0] FLT_RANGE = 2'd2;
    localparam logic [1:0] FLT_OP    = 2'd3;

    typedef struct packed {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } req_t;

    // Op legality and alignment; the range check depends on parameters and lives in the top.
    function automatic logic [1:0] op_fault(input logic we, input logic [2:0] op,
                                            input logic [1:0] lo);
        logic [1:0] cause;
        cause = FLT_NONE;
        if (op == OP_NONE || op > OP_BU || (we && (op == OP_HU || op == OP_BU)))
            cause = FLT_OP;
        else if (op == OP_W && lo != 2'b00)
            cause = FLT_ALIGN;
        else if ((op == OP_H || op == OP_HU) && lo[0])
            cause = FLT_ALIGN;
        return cause;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte/half lane steering: merges store data into the old word and extracts
// sign- or zero-extended load data from it.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] load
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  bit_ofs;

    always_comb begin
        bit_ofs = {addr_lo, 3'b000};
        byte_v  = old_word[bit_ofs +: 8];
        half_v  = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        merged  = old_word;
        load    = '0;
        case (op)
            OP_W: begin
                merged = wdata;
                load   = old_word;
            end
            OP_H, OP_HU: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
                load = (op == OP_H) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
            end
            OP_B, OP_BU: begin
                merged[bit_ofs +: 8] = wdata[7:0];
                load = (op == OP_B) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
            end
            default: begin
                merged = old_word;
                load   = '0;
            end
        endcase
    end

endmodule

// File: rtl/dm_pipelined.sv
// MEM-stage data memory: post-reset clear sweep, fixed-latency request/response
// handshake, sized loads/stores and alignment/range/op fault reporting.
module dm_pipelined
    import dm_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] err_addr,
    output logic        busy
);

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;

    state_t            state, state_nx;
    logic [1:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] clr_idx;
    req_t              pend;
    logic [31:0]       mem [DEPTH];

    logic              accept, commit, fault;
    logic [1:0]        cause;
    logic [31:0]       offset, old_word, merged, load;
    logic [ADDR_W-1:0] word_idx;

    assign req_ready = (state != CLEAR) && (state == IDLE || cnt == 2'd0);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign commit    = (state == PEND) && (cnt == 2'd0);

    // Offset compared in 33 bits so DEPTH*4 never wraps.
    assign offset   = pend.addr - BASE_ADDR;
    assign word_idx = offset[ADDR_W+1:2];
    assign old_word = mem[word_idx];

    always_comb begin
        cause = op_fault(pend.we, pend.op, pend.addr[1:0]);
        if (cause == FLT_NONE && (pend.addr < BASE_ADDR || {1'b0, offset} >= SPAN))
            cause = FLT_RANGE;
    end
    assign fault = (cause != FLT_NONE);

    dm_lane_align u_align (
        .op       (pend.op),
        .addr_lo  (pend.addr[1:0]),
        .old_word (old_word),
        .wdata    (pend.wdata),
        .merged   (merged),
        .load     (load)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CLEAR: if (clr_idx == ADDR_W'(DEPTH - 1)) state_nx = IDLE;
            IDLE: if (accept) begin
                state_nx = PEND;
                cnt_nx   = CNT_INIT;
            end
            PEND: begin
                if (cnt != 2'd0)  cnt_nx = cnt - 2'd1;
                else if (accept)  cnt_nx = CNT_INIT;
                else              state_nx = IDLE;
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            clr_idx   <= '0;
            pend      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_addr  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rsp_valid <= commit;
            if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
            if (accept) pend <= '{req_we, req_op, req_addr, req_wdata, req_pc};
            if (commit) begin
                rsp_err   <= fault;
                rsp_rdata <= (fault || pend.we) ? 32'h0 : load;
                if (fault) err_addr <= pend.addr;
            end
        end
    end

    // Single write port shared by the sweep and committed stores; Reset blocks both.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            if (state == CLEAR)
                mem[clr_idx] <= '0;
            else if (commit && pend.we && !fault)
                mem[word_idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!Reset && commit && pend.we && !fault)
            $display("@%h: *%h <= %h", pend.pc, pend.addr, merged);
    end
`endif

endmodule
